// File: rtl/lemonde_streit_oci_trace_pkg.sv
// Shared constants and state encoding for the Nios II OCI DCT trace packer.
package lemonde_streit_oci_trace_pkg;

    localparam int DCT_CODE_W = 2;
    localparam int DCT_DEPTH  = 15;
    localparam int DCT_BUF_W  = DCT_CODE_W * DCT_DEPTH;
    localparam int DCT_CNT_W  = $clog2(DCT_DEPTH + 1);
    localparam int DCT_FRM_W  = DCT_CNT_W + DCT_BUF_W;

    localparam logic [DCT_CODE_W-1:0] DCT_ILL = 2'b00;
    localparam logic [DCT_CODE_W-1:0] DCT_NT  = 2'b01;
    localparam logic [DCT_CODE_W-1:0] DCT_TK  = 2'b10;
    localparam logic [DCT_CODE_W-1:0] DCT_IND = 2'b11;

    typedef enum logic {
        S_FILL       = 1'b0,
        S_FLUSH_WAIT = 1'b1
    } pack_state_t;

endpackage

// File: rtl/lemonde_streit_oci_frame_reg.sv
// One-entry valid/ready holding register; accepts a load whenever it is empty or draining.
module lemonde_streit_oci_frame_reg #(
    parameter int WIDTH = 34
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             free
);

    assign free = !valid | ready;

    // A load in the same cycle as a drain keeps valid high (back-to-back frames).
    always_ff @(posedge clk) begin
        if (reset) begin
            valid <= 1'b0;
            data  <= '0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
        end else if (ready) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/lemonde_streit_nios2_oci_dct_packer.sv
// Packs 2-bit DCT trace codes into 15-code frames and hands them to a valid/ready output register.
module lemonde_streit_nios2_oci_dct_packer
    import lemonde_streit_oci_trace_pkg::*;
#(
    parameter int CODE_W = DCT_CODE_W,
    parameter int DEPTH  = DCT_DEPTH
) (
    input  logic                                  clk,
    input  logic                                  reset,
    input  logic                                  in_valid,
    input  logic [CODE_W-1:0]                     in_code,
    output logic                                  in_ready,
    input  logic                                  flush,
    output logic [CODE_W*DEPTH-1:0]               dct_buffer,
    output logic [$clog2(DEPTH+1)-1:0]            dct_count,
    output logic                                  frm_valid,
    output logic [$clog2(DEPTH+1)+CODE_W*DEPTH-1:0] frm_data,
    input  logic                                  frm_ready,
    output logic                                  code_err
);

    localparam int BUF_W = CODE_W * DEPTH;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

    pack_state_t            state, state_next;
    logic [BUF_W-1:0]       buffer, buffer_next, buffer_upd;
    logic [CNT_W-1:0]       count, count_next, count_upd;
    logic                   out_free, accept, acc_legal, emit;
    logic [CNT_W+BUF_W-1:0] frame_in;

    assign in_ready  = (state == S_FILL) & !((count == LAST_CNT) & !out_free);
    assign accept    = in_valid & in_ready;
    assign acc_legal = accept & (in_code != DCT_ILL);

    assign buffer_upd = acc_legal ? {buffer[BUF_W-CODE_W-1:0], in_code} : buffer;
    assign count_upd  = acc_legal ? count + 1'b1 : count;
    assign frame_in   = {count_upd, buffer_upd};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_FILL;
            buffer   <= '0;
            count    <= '0;
            code_err <= 1'b0;
        end else begin
            state  <= state_next;
            buffer <= buffer_next;
            count  <= count_next;
            if (accept && in_code == DCT_ILL) begin
                code_err <= 1'b1;
            end
        end
    end

    // A full frame takes priority over a coincident flush so only one frame leaves.
    // in_ready already guarantees the output register is free when the 15th code lands.
    always_comb begin
        state_next  = state;
        buffer_next = buffer_upd;
        count_next  = count_upd;
        emit        = 1'b0;
        case (state)
            S_FILL: begin
                if (count_upd == FULL_CNT) begin
                    emit = 1'b1;
                end else if (flush && count_upd != '0) begin
                    if (out_free) begin
                        emit = 1'b1;
                    end else begin
                        state_next = S_FLUSH_WAIT;
                    end
                end
            end
            S_FLUSH_WAIT: begin
                if (out_free) begin
                    emit       = 1'b1;
                    state_next = S_FILL;
                end
            end
            default: begin
                state_next = S_FILL;
            end
        endcase
        if (emit) begin
            buffer_next = '0;
            count_next  = '0;
        end
    end

    lemonde_streit_oci_frame_reg #(
        .WIDTH(CNT_W + BUF_W)
    ) u_frame_reg (
        .clk       (clk),
        .reset     (reset),
        .load      (emit),
        .load_data (frame_in),
        .ready     (frm_ready),
        .valid     (frm_valid),
        .data      (frm_data),
        .free      (out_free)
    );

    assign dct_buffer = buffer;
    assign dct_count  = count;

endmodule

// File: tb/tb_lemonde_streit_nios2_oci_dct_packer.sv
// Self-checking bench for the DCT packer: vector table plus frame scoreboard and corner-case sequences.
module tb_lemonde_streit_nios2_oci_dct_packer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [1:0]  in_code;
    logic        in_ready;
    logic        flush;
    logic [29:0] dct_buffer;
    logic [3:0]  dct_count;
    logic        frm_valid;
    logic [33:0] frm_data;
    logic        frm_ready;
    logic        code_err;

    int checks   = 0;
    int failures = 0;
    logic [33:0] sb_q[$];

    typedef struct {
        int          n;
        logic [29:0] pattern;
        int          mode;
        logic [33:0] exp_frame;
    } vec_t;

    vec_t vecs[8];

    lemonde_streit_nios2_oci_dct_packer dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_code    (in_code),
        .in_ready   (in_ready),
        .flush      (flush),
        .dct_buffer (dct_buffer),
        .dct_count  (dct_count),
        .frm_valid  (frm_valid),
        .frm_data   (frm_data),
        .frm_ready  (frm_ready),
        .code_err   (code_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [33:0] act, input logic [33:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one code (optionally with flush) and holds it until accepted, bounded.
    task automatic applyStimulus(input logic [1:0] code, input logic fl);
        int budget;
        budget   = 0;
        in_valid = 1'b1;
        in_code  = code;
        flush    = fl;
        while (!in_ready && budget < 50) begin
            @(posedge clk);
            #1;
            budget++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("[TB] FAIL accept_timeout actual=in_ready_low required=accept");
        end else begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic pulseFlush();
        in_valid = 1'b0;
        flush    = 1'b1;
        @(posedge clk);
        #1;
        flush    = 1'b0;
    endtask

    task automatic feedPattern(input int n, input logic [29:0] p, input logic last_flush);
        logic [29:0] pat;
        pat = p;
        for (int i = n - 1; i >= 0; i--) begin
            applyStimulus(pat[2*i +: 2], (i == 0) ? last_flush : 1'b0);
        end
    endtask

    // Every handshake observed on the output must match the oldest expected frame.
    task automatic monitorFrames();
        logic [33:0] exp;
        forever begin
            @(negedge clk);
            if (!reset && frm_valid && frm_ready) begin
                if (sb_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL sb_unexpected actual=%h required=no_frame", frm_data);
                end else begin
                    exp = sb_q.pop_front();
                    checkOutput("sb_frame", frm_data, exp);
                end
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{15, 30'h2AAAAAAA, 0, {4'hF, 30'h2AAAAAAA}};
        vecs[1] = '{3,  30'h0000001B, 1, {4'd3, 30'h0000001B}};
        vecs[2] = '{1,  30'h00000003, 1, {4'd1, 30'h00000003}};
        vecs[3] = '{15, 30'h15555555, 0, {4'hF, 30'h15555555}};
        vecs[4] = '{8,  30'h00006DB6, 1, {4'd8, 30'h00006DB6}};
        vecs[5] = '{15, 30'h1B6DB6DB, 2, {4'hF, 30'h1B6DB6DB}};
        vecs[6] = '{3,  30'h0000001B, 2, {4'd3, 30'h0000001B}};
        vecs[7] = '{14, 30'h0AAAAAAA, 1, {4'hE, 30'h0AAAAAAA}};

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_code   = 2'b00;
        flush     = 1'b0;
        frm_ready = 1'b1;
        fork
            monitorFrames();
        join_none
        waitCycles(3);
        reset = 1'b0;
        #1;

        checkOutput("rst_buffer", {4'd0, dct_buffer}, 34'd0);
        checkOutput("rst_count", {30'd0, dct_count}, 34'd0);
        checkOutput("rst_frm_valid", {33'd0, frm_valid}, 34'd0);
        checkOutput("rst_frm_data", frm_data, 34'd0);
        checkOutput("rst_code_err", {33'd0, code_err}, 34'd0);
        checkOutput("rst_in_ready", {33'd0, in_ready}, 34'd1);

        $display("[TB] vector table");
        for (int v = 0; v < 8; v++) begin
            sb_q.push_back(vecs[v].exp_frame);
            if (vecs[v].mode == 1) begin
                feedPattern(vecs[v].n, vecs[v].pattern, 1'b0);
                checkOutput("live_count", {30'd0, dct_count}, {30'd0, vecs[v].exp_frame[33:30]});
                checkOutput("live_buffer", {4'd0, dct_buffer}, {4'd0, vecs[v].exp_frame[29:0]});
                pulseFlush();
            end else begin
                feedPattern(vecs[v].n, vecs[v].pattern, vecs[v].mode == 2);
            end
            checkOutput("emit_valid", {33'd0, frm_valid}, 34'd1);
            checkOutput("emit_data", frm_data, vecs[v].exp_frame);
            waitCycles(2);
            checkOutput("clear_count", {30'd0, dct_count}, 34'd0);
            checkOutput("clear_buffer", {4'd0, dct_buffer}, 34'd0);
        end

        $display("[TB] backpressure at 14 codes");
        frm_ready = 1'b0;
        sb_q.push_back({4'hF, 30'h2AAAAAAA});
        feedPattern(15, 30'h2AAAAAAA, 1'b0);
        sb_q.push_back({4'hF, 30'h15555555});
        feedPattern(14, 30'h05555555, 1'b0);
        checkOutput("bp_in_ready", {33'd0, in_ready}, 34'd0);
        checkOutput("bp_count", {30'd0, dct_count}, 34'd14);
        checkOutput("bp_hold_data", frm_data, {4'hF, 30'h2AAAAAAA});
        in_valid  = 1'b1;
        in_code   = 2'b01;
        frm_ready = 1'b1;
        #1;
        checkOutput("bp_release_ready", {33'd0, in_ready}, 34'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checkOutput("b2b_valid", {33'd0, frm_valid}, 34'd1);
        checkOutput("b2b_data", frm_data, {4'hF, 30'h15555555});
        waitCycles(2);
        checkOutput("bp_clear_count", {30'd0, dct_count}, 34'd0);

        $display("[TB] flush while frame held");
        frm_ready = 1'b0;
        sb_q.push_back({4'hF, 30'h3FFFFFFF});
        feedPattern(15, 30'h3FFFFFFF, 1'b0);
        applyStimulus(2'b01, 1'b0);
        applyStimulus(2'b11, 1'b0);
        pulseFlush();
        checkOutput("fw_in_ready", {33'd0, in_ready}, 34'd0);
        checkOutput("fw_count", {30'd0, dct_count}, 34'd2);
        checkOutput("fw_buffer", {4'd0, dct_buffer}, 34'h7);
        pulseFlush();
        waitCycles(2);
        checkOutput("fw_still_held", frm_data, {4'hF, 30'h3FFFFFFF});
        sb_q.push_back({4'd2, 30'h7});
        frm_ready = 1'b1;
        waitCycles(3);
        checkOutput("fw_return_ready", {33'd0, in_ready}, 34'd1);
        checkOutput("fw_clear_count", {30'd0, dct_count}, 34'd0);
        checkOutput("fw_valid_idle", {33'd0, frm_valid}, 34'd0);

        $display("[TB] illegal codes and empty flush");
        applyStimulus(2'b01, 1'b0);
        applyStimulus(2'b00, 1'b0);
        checkOutput("ill_count", {30'd0, dct_count}, 34'd1);
        checkOutput("ill_buffer", {4'd0, dct_buffer}, 34'h1);
        checkOutput("ill_err", {33'd0, code_err}, 34'd1);
        applyStimulus(2'b10, 1'b0);
        sb_q.push_back({4'd2, 30'h6});
        pulseFlush();
        waitCycles(2);
        pulseFlush();
        applyStimulus(2'b00, 1'b1);
        waitCycles(3);
        checkOutput("empty_flush_no_frame", {33'd0, frm_valid}, 34'd0);
        checkOutput("ill_err_sticky", {33'd0, code_err}, 34'd1);

        $display("[TB] reset mid-frame");
        frm_ready = 1'b0;
        feedPattern(15, 30'h2AAAAAAA, 1'b0);
        feedPattern(7, 30'h00003FFF, 1'b0);
        checkOutput("pre_rst_count", {30'd0, dct_count}, 34'd7);
        checkOutput("pre_rst_valid", {33'd0, frm_valid}, 34'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("mid_rst_buffer", {4'd0, dct_buffer}, 34'd0);
        checkOutput("mid_rst_count", {30'd0, dct_count}, 34'd0);
        checkOutput("mid_rst_valid", {33'd0, frm_valid}, 34'd0);
        checkOutput("mid_rst_data", frm_data, 34'd0);
        checkOutput("mid_rst_err", {33'd0, code_err}, 34'd0);
        reset     = 1'b0;
        frm_ready = 1'b1;
        waitCycles(3);
        checkOutput("post_rst_no_frame", {33'd0, frm_valid}, 34'd0);

        checkOutput("sb_empty", 34'(sb_q.size()), 34'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
